// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Rounded division so that odd clock/baud ratios land on the nearest count.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period counter: wraps to 0 after the terminal count and flags it.
module uart_baud_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Arstn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic [CNT_W-1:0] term_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == term_i);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Arstn) begin
        if (!Arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one word per valid/ready handshake, LSB first, optional parity.
module uart_tx #(
    parameter int CLK_FREQ  = 7372800,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Arstn,
    input  logic [DATA_BITS-1:0] Tx_data,
    input  logic                 Tx_valid,
    output logic                 Tx_ready,
    output logic                 Uart_tx,
    output logic                 Busy
);

    import uart_pkg::*;

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = (CPB > 2) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] TERM      = CW'(CPB - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam bit            HAS_PAR   = (PARITY != int'(PAR_NONE));
    localparam bit            ODD_PAR   = (PARITY == int'(PAR_ODD));

    if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
        $error("uart_tx: illegal parameter combination");
    end

    tx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [3:0]           bit_q, bit_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 tick;

    // Counter is held at zero while idle so bit timing starts at the handshake.
    uart_baud_cnt #(.CNT_W(CW)) u_baud (
        .Clk        (Clk),
        .Arstn      (Arstn),
        .clr_i      (state_q == IDLE),
        .load_i     (1'b0),
        .load_val_i ('0),
        .term_i     (TERM),
        .tick_o     (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        par_d   = par_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                if (Tx_valid && ready_q) begin
                    shreg_d = Tx_data;
                    par_d   = ODD_PAR ? ~^Tx_data : ^Tx_data;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    tx_d    = shreg_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (HAS_PAR) begin
                            tx_d    = par_q;
                            state_d = uart_pkg::PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                        bit_d   = bit_q + 4'd1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (tick) begin
                    tx_d    = 1'b1;
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        ready_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Arstn) begin
        if (!Arstn) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    assign Uart_tx  = tx_q;
    assign Tx_ready = ready_q;
    assign Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four parameterisations driven from a vector table plus corner sequences.
module tb_uart_tx;

    localparam int CPB = 64;

    logic            clk;
    logic            rst_n;
    logic [3:0]      vld;
    logic [3:0][8:0] dat;
    wire  [3:0]      rdy;
    wire  [3:0]      ln;
    wire  [3:0]      bsy;

    int n_cmp = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: defaults, 1: even parity, 2: odd parity, 3: 7 data bits + 2 stop bits
    uart_tx u_def (
        .Clk(clk), .Arstn(rst_n), .Tx_data(dat[0][7:0]), .Tx_valid(vld[0]),
        .Tx_ready(rdy[0]), .Uart_tx(ln[0]), .Busy(bsy[0]));
    uart_tx #(.PARITY(2)) u_pe (
        .Clk(clk), .Arstn(rst_n), .Tx_data(dat[1][7:0]), .Tx_valid(vld[1]),
        .Tx_ready(rdy[1]), .Uart_tx(ln[1]), .Busy(bsy[1]));
    uart_tx #(.PARITY(1)) u_po (
        .Clk(clk), .Arstn(rst_n), .Tx_data(dat[2][7:0]), .Tx_valid(vld[2]),
        .Tx_ready(rdy[2]), .Uart_tx(ln[2]), .Busy(bsy[2]));
    uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u_d7 (
        .Clk(clk), .Arstn(rst_n), .Tx_data(dat[3][6:0]), .Tx_valid(vld[3]),
        .Tx_ready(rdy[3]), .Uart_tx(ln[3]), .Busy(bsy[3]));

    typedef struct {
        int         inst;
        logic [8:0] data;
        int         nbits;
        logic [11:0] pat;   // expected line level per bit period, bit 0 = start bit
        int         frame;
        int         dbits;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Present a word and return #1 after the accepting edge.
    task automatic handshake(input int i, input logic [8:0] d);
        int t = 0;
        @(negedge clk);
        dat[i] = d;
        vld[i] = 1'b1;
        while (!rdy[i] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("ready before handshake", 32'(rdy[i]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Called #1 after the handshake edge; samples each bit mid-period and decodes the word.
    task automatic mon(input int i, input int nbits, input logic [11:0] pat, input int frame,
                       input int dbits, input logic [8:0] exp_data, input bit toggle, input string nm);
        int n = 0;
        logic [11:0] smp = '0;
        logic [8:0] dec = '0;
        chk({nm, " start latency"}, 32'(ln[i]), 32'd0);
        chk({nm, " ready drop"}, 32'(rdy[i]), 32'd0);
        while (!rdy[i] && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (toggle && (n % 50) == 0) dat[i] = ~dat[i];
            if ((n % CPB) == CPB / 2 && (n / CPB) < nbits) begin
                smp[n / CPB] = ln[i];
                chk($sformatf("%s bit%0d", nm, n / CPB), 32'(ln[i]), 32'(pat[n / CPB]));
            end
            if (n == CPB / 2) chk({nm, " busy"}, 32'(bsy[i]), 32'd1);
        end
        chk({nm, " frame clks"}, 32'(n), 32'(frame));
        chk({nm, " idle line"}, 32'(ln[i]), 32'd1);
        chk({nm, " busy end"}, 32'(bsy[i]), 32'd0);
        for (int b = 0; b < dbits; b++) dec[b] = smp[b + 1];
        chk({nm, " decoded"}, 32'(dec), 32'(exp_data & 9'((1 << dbits) - 1)));
    endtask

    initial begin
        tbl[0] = '{0, 9'h055, 10, 12'h2AA, 640, 8};
        tbl[1] = '{1, 9'h055, 11, 12'h4AA, 704, 8};
        tbl[2] = '{2, 9'h055, 11, 12'h6AA, 704, 8};
        tbl[3] = '{2, 9'h007, 11, 12'h40E, 704, 8};
        tbl[4] = '{3, 9'h07F, 10, 12'h3FE, 640, 7};

        rst_n = 1'b0;
        vld   = '0;
        dat   = '0;
        repeat (3) @(negedge clk);
        chk("reset line", 32'(ln), 32'hF);
        chk("reset ready", 32'(rdy), 32'hF);
        chk("reset busy", 32'(bsy), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            handshake(tbl[v].inst, tbl[v].data);
            vld[tbl[v].inst] = 1'b0;
            mon(tbl[v].inst, tbl[v].nbits, tbl[v].pat, tbl[v].frame, tbl[v].dbits,
                tbl[v].data, 1'b0, $sformatf("vec%0d", v));
        end

        // Back-to-back: valid stays high, second word must follow after one idle clock.
        handshake(0, 9'h000);
        dat[0] = 9'h0FF;
        mon(0, 10, 12'h200, 640, 8, 9'h000, 1'b0, "b2b0");
        @(posedge clk);
        #1;
        mon(0, 10, 12'h3FE, 640, 8, 9'h0FF, 1'b0, "b2b1");
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Data toggled mid-frame must not leak; next word taken only once ready.
        handshake(0, 9'h03C);
        mon(0, 10, 12'h278, 640, 8, 9'h03C, 1'b1, "tog0");
        dat[0] = 9'h081;
        @(posedge clk);
        #1;
        mon(0, 10, 12'h302, 640, 8, 9'h081, 1'b0, "tog1");
        vld[0] = 1'b0;
        repeat (3) @(negedge clk);

        // Asynchronous reset during data bit 3, then a clean frame.
        handshake(0, 9'h0A5);
        vld[0] = 1'b0;
        repeat (276) @(posedge clk);
        #3;
        chk("pre-reset d3", 32'(ln[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async reset line", 32'(ln[0]), 32'd1);
        chk("async reset ready", 32'(rdy[0]), 32'd1);
        chk("async reset busy", 32'(bsy[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        handshake(0, 9'h0A5);
        vld[0] = 1'b0;
        mon(0, 10, 12'h34A, 640, 8, 9'h0A5, 1'b0, "postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
